// File: rtl/text_line_renderer_if.sv
// ---------------------------------------------------------------------------
// text_line_renderer_if
//   Groups the signals of text_line_renderer other than its clock, reset and
//   pixel enable:
//     * character write port  : wr_en, wr_idx, wr_char
//     * font glyph ROM port   : character_select, rom_addr, rom_col -> ROM,
//                               rom_bit <- ROM (combinational)
//     * video output          : hsync, vsync, video_on, rgb, frame_start
//   Modports
//     master : the surrounding system. It writes characters, hosts the font
//              ROM and consumes the video.
//     slave  : the renderer.
// ---------------------------------------------------------------------------
interface text_line_renderer_if;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [4:0] wr_char;

  logic [4:0] character_select;
  logic [3:0] rom_addr;
  logic [2:0] rom_col;
  logic       rom_bit;

  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [7:0] rgb;
  logic       frame_start;

  modport master (
    output wr_en, wr_idx, wr_char, rom_bit,
    input  character_select, rom_addr, rom_col,
    input  hsync, vsync, video_on, rgb, frame_start
  );

  modport slave (
    input  wr_en, wr_idx, wr_char, rom_bit,
    output character_select, rom_addr, rom_col,
    output hsync, vsync, video_on, rgb, frame_start
  );
endinterface

// File: rtl/text_line_renderer.sv
// ---------------------------------------------------------------------------
// text_line_renderer
//   Generates 640x480@60 raster timing and overlays one line of N_CHARS text
//   characters at (ORG_X, ORG_Y). Pixels come from an external font glyph
//   ROM and are returned as RGB332 video.
//
//   Characters are written into a shadow buffer. The shadow buffer is copied
//   to the display buffer once per frame, at the raster wrap to (0,0), so
//   the text never changes partway through a frame.
//
//   Pipeline, advanced only on pix_ce:
//     stage 0 : combinational decode of h_cnt/v_cnt
//     stage 1 : registered ROM address (character_select/rom_addr/rom_col)
//     stage 2 : registered rgb, with hsync/vsync/video_on aligned to rgb
//
//   Ports
//     clk, rst_n : system clock, asynchronous active-low reset
//     pix_ce     : pixel-rate enable (one clk in two at 50 MHz)
//     bus        : text_line_renderer_if.slave. Carries the write port, the
//                  font ROM port and the video outputs.
//
//   Optional feature
//     TEXT_SCALE2_EN : when defined, glyphs are drawn at 2x size. The text
//                      box becomes 16*N_CHARS wide and 32 lines tall. Latency
//                      and timing do not change.
// ---------------------------------------------------------------------------
module text_line_renderer #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          N_CHARS  = 16,
  parameter int          ORG_X    = 256,
  parameter int          ORG_Y    = 224,
  parameter logic [7:0]  FG_COLOR = 8'hFF,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_ce,
  text_line_renderer_if.slave   bus
);

`ifdef TEXT_SCALE2_EN
  localparam int SCALE_LOG2 = 1;
`else
  localparam int SCALE_LOG2 = 0;
`endif

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] TX_X0    = 10'(ORG_X);
  localparam logic [9:0] TX_X1    = 10'(ORG_X + ((8 * N_CHARS) << SCALE_LOG2));
  localparam logic [9:0] TX_Y0    = 10'(ORG_Y);
  localparam logic [9:0] TX_Y1    = 10'(ORG_Y + (16 << SCALE_LOG2));

  localparam logic [4:0] N_SLOTS  = 5'(N_CHARS);
  localparam logic [4:0] BLANK    = 5'd15;

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  logic [9:0] h_cnt, v_cnt;
  logic       h_wrap, frame_wrap;

  assign h_wrap     = (h_cnt == H_LAST);
  assign frame_wrap = h_wrap && (v_cnt == V_LAST);

  // NOTE: every clocked block uses non-blocking assignments. Each block then
  // reads the values that were present before the edge. The frame copy
  // depends on this: it takes the old shadow contents, so a write on the
  // same edge lands in the shadow buffer only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Character buffers. Each has 16 slots, because the index is always 4
  // bits wide. Only slots below N_CHARS are ever written or displayed.
  // ---------------------------------------------------------------------
  logic [4:0] shadow [16];
  logic [4:0] disp   [16];
  logic       wr_ok;

  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_idx} < N_SLOTS);

  // NOTE: both buffers are small flop arrays, not RAM. They are reset so
  // that the screen comes up blank without a software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= BLANK;
        disp[i]   <= BLANK;
      end
      bus.frame_start <= 1'b0;
    end else begin
      if (wr_ok) shadow[bus.wr_idx] <= bus.wr_char;
      if (pix_ce && frame_wrap) disp <= shadow;
      bus.frame_start <= pix_ce && frame_wrap;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 0: decode of the current raster position
  // ---------------------------------------------------------------------
  logic       active, in_text, hs0, vs0;
  logic [9:0] dx, dy;
  logic [3:0] slot;
  logic [3:0] glyph_row;
  logic [2:0] glyph_col;

  // NOTE: every output of this block gets a value on every pass through it.
  // There is no path that leaves an output unassigned, so no latch is
  // inferred.
  always_comb begin
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs0       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    in_text   = active && (h_cnt >= TX_X0) && (h_cnt < TX_X1)
                       && (v_cnt >= TX_Y0) && (v_cnt < TX_Y1);
    dx        = h_cnt - TX_X0;
    dy        = v_cnt - TX_Y0;
    // Each glyph is 8 columns by 16 rows, with every pixel repeated
    // 2^SCALE_LOG2 times in each direction. Glyph bit 7 is the leftmost
    // pixel, so the column index runs in reverse.
    slot      = 4'(dx >> (3 + SCALE_LOG2));
    glyph_row = 4'(dy >> SCALE_LOG2);
    glyph_col = 3'd7 - 3'(dx >> SCALE_LOG2);
  end

  // ---------------------------------------------------------------------
  // Stages 1 and 2
  // ---------------------------------------------------------------------
  logic active1, in_text1, hs1, vs1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.character_select <= BLANK;
      bus.rom_addr         <= '0;
      bus.rom_col          <= '0;
      active1              <= 1'b0;
      in_text1             <= 1'b0;
      hs1                  <= 1'b1;
      vs1                  <= 1'b1;
      bus.rgb              <= '0;
      bus.hsync            <= 1'b1;
      bus.vsync            <= 1'b1;
      bus.video_on         <= 1'b0;
    end else if (pix_ce) begin
      // Stage 1: present the glyph address to the ROM.
      bus.character_select <= in_text ? disp[slot] : BLANK;
      bus.rom_addr         <= in_text ? glyph_row  : 4'd0;
      bus.rom_col          <= in_text ? glyph_col  : 3'd0;
      active1              <= active;
      in_text1             <= in_text;
      hs1                  <= hs0;
      vs1                  <= vs0;
      // Stage 2: the ROM's answer to stage 1 becomes the pixel colour.
      if (!active1)                     bus.rgb <= '0;
      else if (in_text1 && bus.rom_bit) bus.rgb <= FG_COLOR;
      else                              bus.rgb <= BG_COLOR;
      bus.hsync            <= hs1;
      bus.vsync            <= vs1;
      bus.video_on         <= active1;
    end
  end

endmodule
